// File: rtl/dseq_pkg.sv
// Shared state encoding and pattern codes for the time-shared 010/1001 sequence detector.
// No logic here: constants and types only.
package dseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_Z    = 3'd1,
        ST_ZO   = 3'd2,
        ST_OZ   = 3'd3,
        ST_O    = 3'd4,
        ST_OZZ  = 3'd5
    } dseq_state_t;

    localparam logic PAT_010  = 1'b0;
    localparam logic PAT_1001 = 1'b1;

endpackage

// File: rtl/dseq_engine.sv
// Combinational next-state/hit logic for one channel context; zero latency, no flow control.
// Mealy, overlapping detection of "010" (PAT_010) and "1001" (PAT_1001).
module dseq_engine
    import dseq_pkg::*;
(
    input  dseq_state_t state,
    input  logic        x,
    output dseq_state_t next_state,
    output logic        hit,
    output logic        pat
);

    always_comb begin
        next_state = ST_IDLE;
        hit        = 1'b0;
        pat        = PAT_010;
        case (state)
            ST_IDLE: next_state = x ? ST_O  : ST_Z;
            ST_Z:    next_state = x ? ST_ZO : ST_Z;
            ST_ZO: begin
                next_state = x ? ST_O : ST_OZ;
                if (!x) begin
                    hit = 1'b1;
                    pat = PAT_010;
                end
            end
            ST_OZ:   next_state = x ? ST_ZO : ST_OZZ;
            ST_O:    next_state = x ? ST_O  : ST_OZ;
            ST_OZZ: begin
                next_state = x ? ST_ZO : ST_Z;
                if (x) begin
                    hit = 1'b1;
                    pat = PAT_1001;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/dseq_arbiter.sv
// Round-robin share of one detector over NUM_CH bit streams; ready is combinational, match pulses one cycle after the transfer.
// Cleared channels are never granted; DSEQ_MATCH_CNT_EN adds per-channel saturating match counters (cnt_sel/cnt_data).
module dseq_arbiter
    import dseq_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         ch_valid,
    input  logic [NUM_CH-1:0]         ch_bit,
    output logic [NUM_CH-1:0]         ch_ready,
    input  logic [NUM_CH-1:0]         ch_clear,
    output logic                      match_valid,
    output logic [$clog2(NUM_CH)-1:0] match_ch,
    output logic                      match_pat
`ifdef DSEQ_MATCH_CNT_EN
    ,
    input  logic [$clog2(NUM_CH)-1:0] cnt_sel,
    output logic [CNT_W-1:0]          cnt_data
`endif
);

    localparam int IDX_W = $clog2(NUM_CH);

    dseq_state_t      ctx_q [NUM_CH];
    dseq_state_t      ctx_d [NUM_CH];
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             match_valid_q, match_valid_d;
    logic [IDX_W-1:0] match_ch_q, match_ch_d;
    logic             match_pat_q, match_pat_d;

    logic [NUM_CH-1:0] elig;
    logic              gnt_any;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  cand;
    dseq_state_t       eng_state, eng_next;
    logic              eng_x, eng_hit, eng_pat;

    // A channel being cleared this cycle is masked so clear always wins over data.
    assign elig = ch_valid & ~ch_clear;

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_CH);
            if (!gnt_any && elig[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        ch_ready          = '0;
        ch_ready[gnt_idx] = gnt_any;
    end

    assign eng_state = ctx_q[gnt_idx];
    assign eng_x     = ch_bit[gnt_idx];

    dseq_engine u_engine (
        .state      (eng_state),
        .x          (eng_x),
        .next_state (eng_next),
        .hit        (eng_hit),
        .pat        (eng_pat)
    );

    always_comb begin
        ctx_d = ctx_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_clear[i]) begin
                ctx_d[i] = ST_IDLE;
            end
        end
        if (gnt_any) begin
            ctx_d[gnt_idx] = eng_next;
        end

        ptr_d         = gnt_any ? gnt_idx : ptr_q;
        match_valid_d = gnt_any & eng_hit;
        match_ch_d    = match_valid_d ? gnt_idx : match_ch_q;
        match_pat_d   = match_valid_d ? eng_pat : match_pat_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ctx_q[i] <= ST_IDLE;
            end
            ptr_q         <= IDX_W'(NUM_CH - 1);
            match_valid_q <= 1'b0;
            match_ch_q    <= '0;
            match_pat_q   <= 1'b0;
        end else begin
            ctx_q         <= ctx_d;
            ptr_q         <= ptr_d;
            match_valid_q <= match_valid_d;
            match_ch_q    <= match_ch_d;
            match_pat_q   <= match_pat_d;
        end
    end

    assign match_valid = match_valid_q;
    assign match_ch    = match_ch_q;
    assign match_pat   = match_pat_q;

`ifdef DSEQ_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];
    logic [CNT_W-1:0] cnt_data_q, cnt_data_d;

    // Counters bump on the same edge that raises match_valid and stick at all-ones.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ch_clear[i]) begin
                cnt_d[i] = '0;
            end else if (match_valid_d && (gnt_idx == IDX_W'(i)) && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        cnt_data_d = cnt_q[cnt_sel];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            cnt_data_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            cnt_data_q <= cnt_data_d;
        end
    end

    assign cnt_data = cnt_data_q;
`endif

endmodule

// File: tb/tb_dseq_arbiter.sv
// Bench for dseq_arbiter: directed scenarios plus random traffic against a per-channel bit-history model.
`timescale 1ns/1ps
module tb_dseq_arbiter;

    localparam int N  = 4;
    localparam int CW = 2;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  ch_valid, ch_bit, ch_clear, ch_ready;
    logic          match_valid;
    logic [IW-1:0] match_ch;
    logic          match_pat;
`ifdef DSEQ_MATCH_CNT_EN
    logic [IW-1:0] cnt_sel;
    logic [CW-1:0] cnt_data;
`endif

    always #5 clk = ~clk;

    dseq_arbiter #(.NUM_CH(N), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .ch_valid    (ch_valid),
        .ch_bit      (ch_bit),
        .ch_ready    (ch_ready),
        .ch_clear    (ch_clear),
        .match_valid (match_valid),
        .match_ch    (match_ch),
        .match_pat   (match_pat)
`ifdef DSEQ_MATCH_CNT_EN
        ,
        .cnt_sel     (cnt_sel),
        .cnt_data    (cnt_data)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference: each channel remembers its last 4 bits since reset/clear.
    logic [3:0] hist  [N];
    int         nbits [N];
    int         mcnt  [N];
    int         last_g;
    logic       exp_mv;
    int         exp_mch;
    logic       exp_mpat;
    int         exp_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            hist[i]  = '0;
            nbits[i] = 0;
            mcnt[i]  = 0;
        end
        last_g   = N - 1;
        exp_mv   = 1'b0;
        exp_mch  = 0;
        exp_mpat = 1'b0;
        exp_cnt  = 0;
    endtask

    task automatic do_reset();
        ch_valid = '0;
        ch_bit   = '0;
        ch_clear = '0;
`ifdef DSEQ_MATCH_CNT_EN
        cnt_sel  = '0;
`endif
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_match_valid", match_valid, 0);
        check("rst_match_ch", match_ch, 0);
        check("rst_match_pat", match_pat, 0);
`ifdef DSEQ_MATCH_CNT_EN
        check("rst_cnt_data", cnt_data, 0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One cycle: drive, check grant, advance model, clock, check registered outputs.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] b, input logic [N-1:0] c, input int sel);
        int         g;
        logic [N-1:0] exp_rdy;
        logic       hit;
        logic       pat;
        ch_valid = v;
        ch_bit   = b;
        ch_clear = c;
`ifdef DSEQ_MATCH_CNT_EN
        cnt_sel  = IW'(sel);
`endif
        g = -1;
        for (int k = 1; k <= N; k++) begin
            int cidx;
            cidx = (last_g + k) % N;
            if (g < 0 && v[cidx] && !c[cidx]) g = cidx;
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        #1;
        check("ch_ready", ch_ready, exp_rdy);

        exp_cnt = mcnt[sel];
        hit = 1'b0;
        pat = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (c[i]) begin
                hist[i]  = '0;
                nbits[i] = 0;
                mcnt[i]  = 0;
            end
        end
        if (g >= 0) begin
            hist[g] = {hist[g][2:0], b[g]};
            if (nbits[g] < 4) nbits[g]++;
            if (nbits[g] >= 3 && hist[g][2:0] == 3'b010) begin
                hit = 1'b1;
                pat = 1'b0;
            end else if (nbits[g] >= 4 && hist[g] == 4'b1001) begin
                hit = 1'b1;
                pat = 1'b1;
            end
            if (hit) begin
                if (mcnt[g] < (1 << CW) - 1) mcnt[g]++;
                exp_mch  = g;
                exp_mpat = pat;
            end
            last_g = g;
        end
        exp_mv = hit;

        @(posedge clk);
        #1;
        check("match_valid", match_valid, exp_mv);
        check("match_ch", match_ch, exp_mch);
        check("match_pat", match_pat, exp_mpat);
`ifdef DSEQ_MATCH_CNT_EN
        check("cnt_data", cnt_data, exp_cnt);
`endif
    endtask

    initial begin
        do_reset();

        // First request after reset: channel 0 has priority.
        step(4'b1111, 4'b0000, 4'b0000, 0);
        do_reset();

        // Channel 0: 0,1,0 -> pattern 0 on channel 0.
        step(4'b0001, 4'b0000, 4'b0000, 0);
        step(4'b0001, 4'b0001, 4'b0000, 0);
        step(4'b0001, 4'b0000, 4'b0000, 0);
        check("d031_valid", match_valid, 1);
        check("d031_ch", match_ch, 0);
        check("d031_pat", match_pat, 0);

        // Channel 2: 1,0,0,1,0 -> pattern 1 then overlapping pattern 0.
        step(4'b0100, 4'b0100, 4'b0000, 0);
        step(4'b0100, 4'b0000, 4'b0000, 0);
        step(4'b0100, 4'b0000, 4'b0000, 0);
        step(4'b0100, 4'b0100, 4'b0000, 0);
        check("d032_pat1", match_pat, 1);
        step(4'b0100, 4'b0000, 4'b0000, 0);
        check("d032_pat0", match_pat, 0);
        step(4'b0000, 4'b0000, 4'b0000, 0);
        check("d032_hold_ch", match_ch, 2);

        // All channels valid: strict rotation.
        for (int k = 0; k < 12; k++) begin
            step(4'b1111, 4'($urandom), 4'b0000, 0);
        end

        // Channels 1 and 3 interleaved, each 0,1,0.
        do_reset();
        step(4'b0010, 4'b0000, 4'b0000, 0);
        step(4'b1000, 4'b0000, 4'b0000, 0);
        step(4'b0010, 4'b0010, 4'b0000, 0);
        step(4'b1000, 4'b1000, 4'b0000, 0);
        step(4'b0010, 4'b0000, 4'b0000, 0);
        check("d034_ch1", match_ch, 1);
        step(4'b1000, 4'b0000, 4'b0000, 0);
        check("d034_ch3", match_ch, 3);

        // Clear on channel 0 mid-sequence beats its valid bit.
        step(4'b0001, 4'b0000, 4'b0000, 0);
        step(4'b0001, 4'b0001, 4'b0000, 0);
        step(4'b0001, 4'b0000, 4'b0001, 0);
        check("d035_no_match", match_valid, 0);
        step(4'b0001, 4'b0000, 4'b0000, 0);
        step(4'b0001, 4'b0001, 4'b0000, 0);
        step(4'b0001, 4'b0000, 4'b0000, 0);
        check("d035_full_pattern", match_valid, 1);

`ifdef DSEQ_MATCH_CNT_EN
        // Five overlapping 010 matches on channel 1 saturate a 2-bit counter.
        do_reset();
        for (int k = 0; k < 11; k++) begin
            step(4'b0010, (k % 2 == 1) ? 4'b0010 : 4'b0000, 4'b0000, 1);
        end
        step(4'b0000, 4'b0000, 4'b0000, 1);
        check("d036_saturated", cnt_data, 3);
        step(4'b0000, 4'b0000, 4'b0010, 1);
        step(4'b0000, 4'b0000, 4'b0000, 1);
        check("d036_cleared", cnt_data, 0);
`endif

        // Random traffic with sparse clears and one mid-stream reset.
        for (int k = 0; k < 2000; k++) begin
            logic [N-1:0] rv, rb, rc;
            rv = 4'($urandom);
            rb = 4'($urandom);
            rc = 4'($urandom) & 4'($urandom) & 4'($urandom) & 4'($urandom);
            if (k == 1000) do_reset();
            step(rv, rb, rc, $urandom_range(0, N - 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
